// File: rtl/count_monitor_if.sv
// Sample/status bundle between the upstream counter tap and count_monitor.
// The master side drives samples and clear; the slave side is the monitor itself.
interface count_monitor_if #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned WRAP_W = 8
);
  logic              en;
  logic [WIDTH-1:0]  count_in;
  logic              clr;
  logic [WIDTH-1:0]  last_count;
  logic              wrap_pulse;
  logic              resync_pulse;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              stall;
  logic              jump_err;
  logic [1:0]        state;

  modport master (
    output en, count_in, clr,
    input  last_count, wrap_pulse, resync_pulse, wrap_cnt, stall, jump_err, state
  );

  modport slave (
    input  en, count_in, clr,
    output last_count, wrap_pulse, resync_pulse, wrap_cnt, stall, jump_err, state
  );
endinterface

// File: rtl/count_monitor.sv
// Downstream checker for a WIDTH-bit up counter: tracks wraps, stalls,
// upstream resets and illegal jumps, with registered pulses and sticky flags.
module count_monitor #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned STALL_LIMIT = 8,
  parameter int unsigned WRAP_W      = 8
) (
  input  logic          clk,
  input  logic          rst,
  count_monitor_if.slave mon
);

  localparam int unsigned RUN_W = 8;
  localparam logic [WIDTH-1:0]  CNT_MAX   = '1;
  localparam logic [WRAP_W-1:0] WRAP_MAX  = '1;
  localparam logic [RUN_W-1:0]  RUN_LIMIT = RUN_W'(STALL_LIMIT);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_ERROR = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CL_NORMAL,
    CL_WRAP,
    CL_EQUAL,
    CL_RESYNC,
    CL_JUMP
  } class_e;

  state_e            state_q, state_d;
  class_e            cls;
  logic [WIDTH-1:0]  last_q, last_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              stall_q, stall_d;
  logic              jerr_q, jerr_d;
  logic              wp_q, wp_d;
  logic              rp_q, rp_d;

  // Classify the incoming sample against the last accepted one.
  always_comb begin
    cls = CL_JUMP;
    if (mon.count_in == last_q) begin
      cls = CL_EQUAL;
    end else if (last_q == CNT_MAX && mon.count_in == '0) begin
      cls = CL_WRAP;
    end else if (last_q != CNT_MAX && mon.count_in == last_q + WIDTH'(1)) begin
      cls = CL_NORMAL;
    end else if (mon.count_in == '0) begin
      cls = CL_RESYNC;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_INIT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (mon.clr) begin
      state_d = ST_INIT;
    end else if (mon.en) begin
      case (state_q)
        ST_INIT:  state_d = ST_TRACK;
        ST_TRACK: if (cls == CL_JUMP) state_d = ST_ERROR;
        ST_ERROR: state_d = ST_ERROR;
        default:  state_d = ST_INIT;
      endcase
    end
  end

  // Next values of the registered outputs; clr wins over a same-edge sample.
  always_comb begin
    last_d  = last_q;
    wrap_d  = wrap_q;
    run_d   = run_q;
    stall_d = stall_q;
    jerr_d  = jerr_q;
    wp_d    = 1'b0;
    rp_d    = 1'b0;
    if (mon.clr) begin
      wrap_d  = '0;
      run_d   = '0;
      stall_d = 1'b0;
      jerr_d  = 1'b0;
    end else if (mon.en) begin
      case (state_q)
        ST_INIT: last_d = mon.count_in;
        ST_TRACK: begin
          case (cls)
            CL_NORMAL: begin
              last_d  = mon.count_in;
              run_d   = '0;
              stall_d = 1'b0;
            end
            CL_WRAP: begin
              wp_d    = 1'b1;
              if (wrap_q != WRAP_MAX) wrap_d = wrap_q + WRAP_W'(1);
              last_d  = '0;
              run_d   = '0;
              stall_d = 1'b0;
            end
            CL_EQUAL: begin
              if (run_q >= RUN_LIMIT - RUN_W'(1)) begin
                run_d   = RUN_LIMIT;
                stall_d = 1'b1;
              end else begin
                run_d = run_q + RUN_W'(1);
              end
            end
            CL_RESYNC: begin
              rp_d    = 1'b1;
              last_d  = '0;
              run_d   = '0;
              stall_d = 1'b0;
            end
            default: begin
              jerr_d = 1'b1;
              last_d = mon.count_in;
            end
          endcase
        end
        ST_ERROR: last_d = mon.count_in;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q  <= '0;
      wrap_q  <= '0;
      run_q   <= '0;
      stall_q <= 1'b0;
      jerr_q  <= 1'b0;
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
    end else begin
      last_q  <= last_d;
      wrap_q  <= wrap_d;
      run_q   <= run_d;
      stall_q <= stall_d;
      jerr_q  <= jerr_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
    end
  end

  assign mon.last_count   = last_q;
  assign mon.wrap_pulse   = wp_q;
  assign mon.resync_pulse = rp_q;
  assign mon.wrap_cnt     = wrap_q;
  assign mon.stall        = stall_q;
  assign mon.jump_err     = jerr_q;
  assign mon.state        = state_q;

endmodule

// File: tb/tb_count_monitor.sv
// Self-checking bench for count_monitor: directed vector table, wrap
// saturation and async reset sequences, then random stimulus against a model.
module tb_count_monitor;

  localparam int unsigned WIDTH       = 4;
  localparam int unsigned STALL_LIMIT = 8;
  localparam int unsigned WRAP_W      = 2;
  localparam int CMAX = (1 << WIDTH) - 1;
  localparam int WMAX = (1 << WRAP_W) - 1;

  typedef logic [2+WIDTH+1+1+WRAP_W+1+1-1:0] obs_t;

  typedef struct {
    bit en;
    bit clr;
    int c;
    int st;
    int last;
    bit wp;
    bit rp;
    int wc;
    bit stl;
    bit je;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl[$];

  // Reference model state
  int m_state, m_last, m_wrap, m_run;
  bit m_stall, m_jerr, m_wp, m_rp;

  count_monitor_if #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) bus ();

  count_monitor #(
    .WIDTH(WIDTH),
    .STALL_LIMIT(STALL_LIMIT),
    .WRAP_W(WRAP_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mon(bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t pack(int st, int last, bit wp, bit rp, int wc, bit stl, bit je);
    return {2'(st), WIDTH'(last), wp, rp, WRAP_W'(wc), stl, je};
  endfunction

  function automatic obs_t observed();
    return {bus.state, bus.last_count, bus.wrap_pulse, bus.resync_pulse,
            bus.wrap_cnt, bus.stall, bus.jump_err};
  endfunction

  function automatic obs_t model_obs();
    return pack(m_state, m_last, m_wp, m_rp, m_wrap, m_stall, m_jerr);
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got st/last/wp/rp/wc/stall/jerr=%b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_last = 0; m_wrap = 0; m_run = 0;
    m_stall = 0; m_jerr = 0; m_wp = 0; m_rp = 0;
  endtask

  // Behavioural rules of the monitor, applied once per clock edge.
  task automatic model_step(input bit en, input bit clr, input int c);
    m_wp = 0;
    m_rp = 0;
    if (clr) begin
      m_state = 0; m_wrap = 0; m_run = 0; m_stall = 0; m_jerr = 0;
    end else if (en) begin
      if (m_state == 0) begin
        m_last = c;
        m_state = 1;
      end else if (m_state == 2) begin
        m_last = c;
      end else if (c == m_last) begin
        m_run = (m_run + 1 > STALL_LIMIT) ? STALL_LIMIT : m_run + 1;
        if (m_run == STALL_LIMIT) m_stall = 1;
      end else if (m_last == CMAX && c == 0) begin
        m_wp = 1;
        m_wrap = (m_wrap < WMAX) ? m_wrap + 1 : WMAX;
        m_last = 0; m_run = 0; m_stall = 0;
      end else if (m_last < CMAX && c == m_last + 1) begin
        m_last = c; m_run = 0; m_stall = 0;
      end else if (c == 0) begin
        m_rp = 1;
        m_last = 0; m_run = 0; m_stall = 0;
      end else begin
        m_jerr = 1;
        m_last = c;
        m_state = 2;
      end
    end
  endtask

  task automatic cycle(input bit en, input bit clr, input int c);
    @(negedge clk);
    bus.en       = en;
    bus.clr      = clr;
    bus.count_in = WIDTH'(c);
    @(posedge clk);
    #1;
    model_step(en, clr, c);
  endtask

  task automatic cycle_chk(input string name, input bit en, input bit clr, input int c);
    cycle(en, clr, c);
    check(name, observed(), model_obs());
  endtask

  function automatic void add(bit en, bit clr, int c, int st, int last,
                              bit wp, bit rp, int wc, bit stl, bit je);
    vec_t v;
    v.en = en; v.clr = clr; v.c = c; v.st = st; v.last = last;
    v.wp = wp; v.rp = rp; v.wc = wc; v.stl = stl; v.je = je;
    tbl.push_back(v);
  endfunction

  initial begin
    int pulses;
    int r;
    int c;

    // Directed table: free run with wrap, upstream reset, stall, illegal jump, clear
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 15; i++) add(1, 0, i, 1, i, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 1, 0, 1, 0, 0);
    for (int i = 1; i <= 6; i++) add(1, 0, i, 1, i, 0, 0, 1, 0, 0);
    add(1, 0, 0, 1, 0, 0, 1, 1, 0, 0);
    for (int i = 1; i <= 5; i++) add(1, 0, i, 1, i, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 5, 1, 5, 0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) add(0, 0, 9, 1, 5, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 0, 5, 1, 5, 0, 0, 1, 0, 0);
    add(1, 0, 5, 1, 5, 0, 0, 1, 1, 0);
    add(1, 0, 5, 1, 5, 0, 0, 1, 1, 0);
    add(1, 0, 6, 1, 6, 0, 0, 1, 0, 0);
    add(1, 0, 0, 1, 0, 0, 1, 1, 0, 0);
    for (int i = 1; i <= 3; i++) add(1, 0, i, 1, i, 0, 0, 1, 0, 0);
    add(1, 0, 9,  2, 9,  0, 0, 1, 0, 1);
    add(1, 0, 10, 2, 10, 0, 0, 1, 0, 1);
    add(1, 0, 11, 2, 11, 0, 0, 1, 0, 1);
    add(1, 1, 12, 0, 11, 0, 0, 0, 0, 0);
    add(1, 0, 5,  1, 5,  0, 0, 0, 0, 0);

    bus.en = 1'b0;
    bus.clr = 1'b0;
    bus.count_in = '0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("reset_state", observed(), pack(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].en, tbl[i].clr, tbl[i].c);
      check($sformatf("vec%0d", i), observed(),
            pack(tbl[i].st, tbl[i].last, tbl[i].wp, tbl[i].rp,
                 tbl[i].wc, tbl[i].stl, tbl[i].je));
    end

    // Wrap counter saturation: five wraps, counter sticks at its maximum
    pulses = 0;
    for (int w = 0; w < 5; w++) begin
      for (int k = (w == 0) ? 6 : 1; k <= 15; k++) begin
        cycle_chk("sat_run", 1, 0, k);
        pulses += int'(bus.wrap_pulse);
      end
      cycle_chk("sat_wrap", 1, 0, 0);
      pulses += int'(bus.wrap_pulse);
      check_int("sat_wrap_cnt", int'(bus.wrap_cnt), (w + 1 > WMAX) ? WMAX : w + 1);
    end
    check_int("sat_pulses", pulses, 5);

    // Async reset between edges while tracking with two wraps counted
    cycle_chk("pre_clr", 1, 1, 0);
    cycle_chk("pre_init", 1, 0, 0);
    for (int w = 0; w < 2; w++) begin
      for (int k = 1; k <= 15; k++) cycle(1, 0, k);
      cycle(1, 0, 0);
    end
    check_int("pre_rst_wrap_cnt", int'(bus.wrap_cnt), 2);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", observed(), pack(0, 0, 0, 0, 0, 0, 0));
    model_reset();
    @(negedge clk);
    bus.en = 1'b0;
    rst = 1'b1;

    // Random stimulus biased toward legal counting
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 60)      c = (m_last + 1) % (CMAX + 1);
      else if (r < 75) c = m_last;
      else if (r < 85) c = 0;
      else             c = int'($urandom_range(0, CMAX));
      cycle_chk("random", ($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0), c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
